// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_pkg
// Purpose  : Shared state encoding, default sizes and sizing helpers for the
//            N-channel toggle-handshake SRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  // Access sequencer states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_STROBE = 2'd2;
  localparam state_t ST_HOLD   = 2'd3;

  // Sizes for the default configuration (16-bit SRAM, 3-cycle strobe)
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_STROBE_CYC = 3;
  localparam int NBE            = DEF_DATA_W / 8;
  localparam int CNT_W          = $clog2(DEF_STROBE_CYC + 1);

  // Byte lanes for a given data width
  function automatic int lanes_of(input int data_w);
    return data_w / 8;
  endfunction

  // Strobe counter width able to hold the value strobe_cyc
  function automatic int cnt_w_of(input int strobe_cyc);
    return $clog2(strobe_cyc + 1);
  endfunction

  // Channel index width; a single channel still needs one bit
  function automatic int idx_w_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : sram_rr_picker
// Purpose  : Combinational grant selection. Round-robin mode searches upward
//            from start_i with wrap-around; fixed mode picks the lowest index.
// Revision : 1.0 - initial release
// ============================================================================
module sram_rr_picker
  import sram_arb_pkg::*;
#(
  parameter  int NUM_CH      = 2,
  parameter  int ROUND_ROBIN = 1,
  localparam int IW          = idx_w_of(NUM_CH)
) (
  input  logic [NUM_CH-1:0] want_i,
  input  logic [IW-1:0]     start_i,
  output logic              valid_o,
  output logic [IW-1:0]     grant_o
);

  logic [IW-1:0] idx_w;

  // First wanting channel in search order wins
  always_comb begin
    valid_o = 1'b0;
    grant_o = '0;
    idx_w   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ROUND_ROBIN != 0) idx_w = IW'((int'(start_i) + k) % NUM_CH);
      else                  idx_w = IW'(k);
      if (!valid_o && want_i[idx_w]) begin
        valid_o = 1'b1;
        grant_o = idx_w;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter_nch.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter_nch
// Purpose  : Multiplexes NUM_CH toggle-handshake requesters onto one
//            asynchronous SRAM with configurable strobe length and a write
//            hold cycle. ack[i] toggles when channel i's access completes.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter_nch
  import sram_arb_pkg::*;
#(
  parameter  int NUM_CH      = 2,
  parameter  int ADDR_W      = 20,
  parameter  int DATA_W      = 16,
  parameter  int STROBE_CYC  = 3,
  parameter  int ROUND_ROBIN = 1,
  localparam int LANES       = lanes_of(DATA_W),
  localparam int CW          = cnt_w_of(STROBE_CYC),
  localparam int IW          = idx_w_of(NUM_CH)
) (
  input  logic                     clk200,
  input  logic                     reset_n,
  output logic                     SR_OE_n,
  output logic                     SR_WE_n,
  output logic [LANES-1:0]         SR_BE_n,
  output logic [ADDR_W-1:0]        SR_A,
  inout  wire  [DATA_W-1:0]        SR_D,
  input  logic [NUM_CH-1:0]        req,
  output logic [NUM_CH-1:0]        ack,
  input  logic [NUM_CH-1:0]        rd,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*LANES-1:0]  be,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH*DATA_W-1:0] rdata,
  output logic                     busy
);

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [IW-1:0]            gnt_q, gnt_d;
  logic [IW-1:0]            ptr_q, ptr_d;     // next round-robin search start
  logic                     rd_q, rd_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [ADDR_W-1:0]        a_q, a_d;
  logic [LANES-1:0]         be_n_q, be_n_d;
  logic                     oe_n_q, oe_n_d;
  logic                     we_n_q, we_n_d;
  logic                     drive_q, drive_d; // SR_D output enable
  logic [NUM_CH-1:0]        ack_q, ack_d;
  logic [NUM_CH*DATA_W-1:0] rdata_q, rdata_d;

  logic [NUM_CH-1:0]        want_w;
  logic                     pick_vld_w;
  logic [IW-1:0]            pick_w;

  assign want_w = req ^ ack_q;

  sram_rr_picker #(
    .NUM_CH      (NUM_CH),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_picker (
    .want_i  (want_w),
    .start_i (ptr_q),
    .valid_o (pick_vld_w),
    .grant_o (pick_w)
  );

  // Access sequencer: next-state and next-output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    a_d     = a_q;
    be_n_d  = be_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    drive_d = drive_q;
    ack_d   = ack_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_w) begin
          gnt_d   = pick_w;
          ptr_d   = (pick_w == IW'(NUM_CH - 1)) ? '0 : pick_w + 1'b1;
          rd_d    = rd[pick_w];
          a_d     = addr[pick_w*ADDR_W +: ADDR_W];
          be_n_d  = ~be[pick_w*LANES +: LANES];
          wdata_d = wdata[pick_w*DATA_W +: DATA_W];
          oe_n_d  = ~rd[pick_w];
          we_n_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = CW'(STROBE_CYC);
        state_d = ST_STROBE;
        if (!rd_q) begin
          we_n_d  = 1'b0;
          drive_d = 1'b1;
        end
      end
      ST_STROBE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          if (rd_q) begin
            rdata_d[gnt_q*DATA_W +: DATA_W] = SR_D;
            ack_d[gnt_q] = ~ack_q[gnt_q];
            oe_n_d       = 1'b1;
            be_n_d       = '1;
            state_d      = ST_IDLE;
          end else begin
            // Address and data stay put through the hold cycle
            we_n_d  = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        drive_d      = 1'b0;
        be_n_d       = '1;
        ack_d[gnt_q] = ~ack_q[gnt_q];
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk200 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
      a_q     <= '0;
      be_n_q  <= '1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drive_q <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      a_q     <= a_d;
      be_n_q  <= be_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      drive_q <= drive_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign SR_D    = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign SR_OE_n = oe_n_q;
  assign SR_WE_n = we_n_q;
  assign SR_BE_n = be_n_q;
  assign SR_A    = a_q;
  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter_nch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter_nch
// Purpose  : Directed and randomised bench for sram_arbiter_nch with an
//            asynchronous SRAM model, a byte-lane shadow memory and bus rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter_nch;

  localparam int NCH = 3;
  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int NB  = 2;

  logic clk200  = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk200 = ~clk200;

  // Round-robin instance and its SRAM bus
  logic               oe_n, we_n, busy;
  logic [NB-1:0]      be_n;
  logic [AW-1:0]      sr_a;
  tri1  [DW-1:0]      sr_d;
  logic [NCH-1:0]     req = '0, rd = '0;
  logic [NCH-1:0]     ack;
  logic [NCH*AW-1:0]  addr = '0;
  logic [NCH*NB-1:0]  be = '0;
  logic [NCH*DW-1:0]  wdata = '0;
  logic [NCH*DW-1:0]  rdata;

  // Fixed-priority instance and its SRAM bus
  logic               fp_oe_n, fp_we_n, fp_busy;
  logic [NB-1:0]      fp_be_n;
  logic [AW-1:0]      fp_a;
  tri1  [DW-1:0]      fp_d;
  logic [NCH-1:0]     fp_req = '0, fp_rd = '1;
  logic [NCH-1:0]     fp_ack;
  logic [NCH*AW-1:0]  fp_addr = '0;
  logic [NCH*NB-1:0]  fp_be = '1;
  logic [NCH*DW-1:0]  fp_wdata = '0;
  logic [NCH*DW-1:0]  fp_rdata;

  sram_arbiter_nch #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .STROBE_CYC(3), .ROUND_ROBIN(1)) u_dut (
    .clk200(clk200), .reset_n(reset_n), .SR_OE_n(oe_n), .SR_WE_n(we_n), .SR_BE_n(be_n),
    .SR_A(sr_a), .SR_D(sr_d), .req(req), .ack(ack), .rd(rd), .addr(addr), .be(be),
    .wdata(wdata), .rdata(rdata), .busy(busy));

  sram_arbiter_nch #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .STROBE_CYC(3), .ROUND_ROBIN(0)) u_dut_fp (
    .clk200(clk200), .reset_n(reset_n), .SR_OE_n(fp_oe_n), .SR_WE_n(fp_we_n), .SR_BE_n(fp_be_n),
    .SR_A(fp_a), .SR_D(fp_d), .req(fp_req), .ack(fp_ack), .rd(fp_rd), .addr(fp_addr), .be(fp_be),
    .wdata(fp_wdata), .rdata(fp_rdata), .busy(fp_busy));

  // SRAM models: 256 words decoded from SR_A[7:0]
  logic [DW-1:0] mem    [256];
  logic [DW-1:0] shadow [256];

  assign sr_d = (!oe_n && reset_n) ? mem[sr_a[7:0]] : 16'hzzzz;
  assign fp_d = (!fp_oe_n)         ? {8'hC3, fp_a[7:0]} : 16'hzzzz;

  always @(posedge we_n) begin
    if (reset_n) begin
      for (int l = 0; l < NB; l++)
        if (!be_n[l]) mem[sr_a[7:0]][l*8 +: 8] = sr_d[l*8 +: 8];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: strobe/drive cycle counters, bus rule violations, ack order
  int             n_oe, n_we, n_drv, viol;
  bit             prev_we_low;
  logic [AW-1:0]  prev_a;
  logic [NCH-1:0] ack_prev = '0;
  int             order[$];

  always @(negedge clk200) begin
    if (!oe_n) n_oe++;
    if (!we_n) n_we++;
    if (sr_d == 16'hA55A) n_drv++;
    if (!oe_n && !we_n) viol++;
    if (!oe_n && sr_d != mem[sr_a[7:0]]) viol++;
    if (reset_n && prev_we_low && sr_a != prev_a) viol++;
    prev_we_low = reset_n && !we_n;
    prev_a      = sr_a;
    for (int c = 0; c < NCH; c++)
      if (ack[c] != ack_prev[c]) order.push_back(c);
    ack_prev = ack;
  end

  task automatic issue(input int ch, input bit r, input logic [AW-1:0] a,
                       input logic [NB-1:0] b, input logic [DW-1:0] d);
    rd[ch]              = r;
    addr[ch*AW +: AW]   = a;
    be[ch*NB +: NB]     = b;
    wdata[ch*DW +: DW]  = d;
    if (!r)
      for (int l = 0; l < NB; l++)
        if (b[l]) shadow[a[7:0]][l*8 +: 8] = d[l*8 +: 8];
    req[ch] = ~req[ch];
  endtask

  // Counts rising edges until ack[ch] toggles (100-edge bound)
  task automatic wait_ack(input int ch, output int n);
    logic old;
    old = ack[ch];
    n   = 0;
    while (ack[ch] == old && n < 100) begin
      @(posedge clk200);
      #1;
      n++;
    end
  endtask

  task automatic rr_chan(input int ch);
    int n;
    for (int i = 0; i < 2; i++) begin
      issue(ch, 1'b1, AW'(20'h00050 + ch), 2'b11, 16'h0);
      wait_ack(ch, n);
      check_val("rr_timeout", 64'(n >= 100), 64'd0);
      check_val("rr_rdata", rdata[ch*DW +: DW], shadow[8'h50 + ch]);
      @(negedge clk200);
    end
  endtask

  task automatic rand_chan(input int ch, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      bit            r;
      logic [7:0]    low;
      logic [AW-1:0] a;
      int            n;
      r   = 1'($urandom);
      low = {2'(ch), 6'($urandom_range(0, 63))};
      a   = {12'($urandom), low};
      issue(ch, r, a, 2'($urandom), 16'($urandom));
      wait_ack(ch, n);
      check_val("rand_timeout", 64'(n >= 100), 64'd0);
      if (r) check_val("rand_rdata", rdata[ch*DW +: DW], shadow[low]);
      repeat ($urandom_range(1, 3)) @(negedge clk200);
    end
  endtask

  initial begin
    int n, t0, t2;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 16'(i * 257) ^ 16'h5A5A;
      shadow[i] = mem[i];
    end
    fp_addr[0*AW +: AW] = 20'h00001;
    fp_addr[2*AW +: AW] = 20'h00077;

    // Reset state
    repeat (3) @(negedge clk200);
    reset_n = 1'b1;
    @(negedge clk200);
    check_val("rst_ack", ack, 3'b000);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_strobes", {oe_n, we_n, be_n}, 4'b1111);
    check_val("rst_addr", sr_a, 20'h0);
    check_val("rst_rdata", rdata, 48'h0);
    check_val("rst_sr_d_released", sr_d, 16'hFFFF);

    // Single read, ch0: ack at the 5th edge counting the grant edge
    mem[8'h45] = 16'hBEEF; shadow[8'h45] = 16'hBEEF;
    n_oe = 0;
    issue(0, 1'b1, 20'h12345, 2'b11, 16'h0);
    wait_ack(0, n);
    check_val("rd_latency", n, 5);
    check_val("rd_rdata", rdata[0 +: DW], 16'hBEEF);
    check_val("rd_oe_end", oe_n, 1'b1);
    check_val("rd_busy_end", busy, 1'b0);
    check_val("rd_addr_held", sr_a, 20'h12345);
    @(negedge clk200);
    check_val("rd_oe_cycles", n_oe, 4);

    // Single write, ch1, upper lane only
    mem[8'h10] = 16'h1111; shadow[8'h10] = 16'h1111;
    n_we = 0; n_drv = 0;
    issue(1, 1'b0, 20'h00010, 2'b10, 16'hA55A);
    wait_ack(1, n);
    check_val("wr_latency", n, 6);
    @(negedge clk200);
    check_val("wr_we_cycles", n_we, 3);
    check_val("wr_drive_cycles", n_drv, 4);
    check_val("wr_mem", mem[8'h10], 16'hA511);
    check_val("wr_be_released", be_n, 2'b11);
    check_val("wr_rdata_ch0_untouched", rdata[0 +: DW], 16'hBEEF);

    // be == 0 write: full-length cycle, memory untouched
    issue(2, 1'b0, 20'hABC20, 2'b00, 16'h0F0F);
    wait_ack(2, n);
    check_val("be0_latency", n, 6);
    check_val("be0_mem", mem[8'h20], 16'h7A7A);
    @(negedge clk200);
    issue(2, 1'b1, 20'h00020, 2'b11, 16'h0);
    wait_ack(2, n);
    check_val("be0_readback", rdata[2*DW +: DW], 16'h7A7A);
    @(negedge clk200);

    // Reset during the strobe of a write
    issue(1, 1'b0, 20'h000F3, 2'b11, 16'h1357);
    repeat (3) @(negedge clk200);
    check_val("abort_we_active", we_n, 1'b0);
    #2 reset_n = 1'b0;
    req = '0;
    fp_req = '0;
    #1;
    check_val("abort_we", we_n, 1'b1);
    check_val("abort_sr_d", sr_d, 16'hFFFF);
    check_val("abort_ack", ack, 3'b000);
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_rdata", rdata, 48'h0);
    @(negedge clk200);
    #2 reset_n = 1'b1;
    repeat (4) @(negedge clk200);
    check_val("abort_idle", {busy, oe_n, we_n, ack}, {1'b0, 1'b1, 1'b1, 3'b000});

    // Round-robin with every channel re-requesting immediately
    order.delete();
    fork
      rr_chan(0);
      rr_chan(1);
      rr_chan(2);
    join
    @(negedge clk200);
    check_val("rr_count", order.size(), 6);
    for (int i = 0; i < 6; i++)
      check_val("rr_order", (i < order.size()) ? order[i] : -1, i % 3);

    // Fixed priority: ch0 and ch2 together
    fp_req[0] = ~fp_req[0];
    fp_req[2] = ~fp_req[2];
    t0 = 0; t2 = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk200);
      #1;
      if (fp_ack[0] && t0 == 0) t0 = i;
      if (fp_ack[2] && t2 == 0) t2 = i;
    end
    check_val("fp_ch0_edge", t0, 5);
    check_val("fp_ch2_edge", t2, 10);
    check_val("fp_rdata_ch0", fp_rdata[0 +: DW], 16'hC301);
    check_val("fp_rdata_ch2", fp_rdata[2*DW +: DW], 16'hC377);
    check_val("fp_rdata_ch1", fp_rdata[1*DW +: DW], 16'h0000);
    @(negedge clk200);

    // Random mixed traffic on disjoint address partitions
    fork
      rand_chan(0, 50);
      rand_chan(1, 50);
      rand_chan(2, 50);
    join
    check_val("bus_rules", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
